// File: rtl/mesi_snoop_cache.sv
// Direct-mapped write-back cache controller with MESI snooping for one core on a shared bus.
module mesi_snoop_cache #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned INDEX_W = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [2:0]        bus_cmd,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              bus_shared_in,
  input  logic              snoop_valid,
  input  logic [2:0]        snoop_cmd,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_shared,
  output logic              snoop_flush,
  output logic [DATA_W-1:0] snoop_data
);
  localparam int Lines = 2 ** INDEX_W;
  localparam int TagW  = ADDR_W - INDEX_W;

  localparam logic [1:0] MesiI = 2'd0, MesiS = 2'd1, MesiM = 2'd2, MesiE = 2'd3;
  localparam logic [2:0] CmdNone = 3'd0, CmdRd = 3'd1, CmdRdx = 3'd2, CmdUpgr = 3'd3,
                         CmdWb = 3'd4;

  typedef enum logic [2:0] {StIdle, StWb, StFill, StUpgr, StResp} state_e;

  state_e            state_q, state_d;
  logic [TagW-1:0]   tag_q  [Lines];
  logic [TagW-1:0]   tag_d  [Lines];
  logic [1:0]        mesi_q [Lines];
  logic [1:0]        mesi_d [Lines];
  logic [DATA_W-1:0] data_q [Lines];
  logic [DATA_W-1:0] data_d [Lines];

  logic              bus_req_q, bus_req_d;
  logic [2:0]        bus_cmd_q, bus_cmd_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              snp_shared_q, snp_shared_d;
  logic              snp_flush_q, snp_flush_d;
  logic [DATA_W-1:0] snp_data_q, snp_data_d;

  logic [INDEX_W-1:0] req_idx, snp_idx;
  logic [TagW-1:0]    req_tag, snp_tag;
  logic               req_hit, snp_act;
  logic [1:0]         snp_next;

  assign req_idx = cpu_addr[INDEX_W-1:0];
  assign req_tag = cpu_addr[ADDR_W-1:INDEX_W];
  assign snp_idx = snoop_addr[INDEX_W-1:0];
  assign snp_tag = snoop_addr[ADDR_W-1:INDEX_W];
  assign req_hit = (mesi_q[req_idx] != MesiI) && (tag_q[req_idx] == req_tag);

  // Our own granted transaction shows up on the snoop port; it must not hit ourselves.
  assign snp_act = snoop_valid && !(bus_gnt && (snoop_addr == bus_addr_q)) &&
                   (mesi_q[snp_idx] != MesiI) && (tag_q[snp_idx] == snp_tag);

  // Snoop response and the new state of the snooped line.
  always_comb begin
    snp_next     = mesi_q[snp_idx];
    snp_shared_d = 1'b0;
    snp_flush_d  = 1'b0;
    if (snp_act) begin
      case (snoop_cmd)
        CmdRd: begin
          snp_shared_d = 1'b1;
          snp_flush_d  = (mesi_q[snp_idx] == MesiM);
          snp_next     = MesiS;
        end
        CmdRdx: begin
          snp_flush_d = (mesi_q[snp_idx] == MesiM);
          snp_next    = MesiI;
        end
        CmdUpgr: if (mesi_q[snp_idx] == MesiS) snp_next = MesiI;
        default: ;
      endcase
    end
    snp_data_d = snp_flush_d ? data_q[snp_idx] : '0;
  end

  // Controller FSM and array updates; snoop applied first so core writes override it.
  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    mesi_d      = mesi_q;
    data_d      = data_q;
    bus_req_d   = bus_req_q;
    bus_cmd_d   = bus_cmd_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    if (snp_act) mesi_d[snp_idx] = snp_next;
    case (state_q)
      StIdle: begin
        // Stall a lookup colliding with a snoop so it sees the post-snoop state next cycle.
        if (cpu_req && !(snp_act && (snp_idx == req_idx))) begin
          if (req_hit && !cpu_we) begin
            rdata_d = data_q[req_idx];
            state_d = StResp;
          end else if (req_hit && (mesi_q[req_idx] == MesiS)) begin
            bus_req_d   = 1'b1;
            bus_cmd_d   = CmdUpgr;
            bus_addr_d  = cpu_addr;
            bus_wdata_d = '0;
            state_d     = StUpgr;
          end else if (req_hit) begin
            mesi_d[req_idx] = MesiM;
            data_d[req_idx] = cpu_wdata;
            rdata_d         = cpu_wdata;
            state_d         = StResp;
          end else if (mesi_q[req_idx] == MesiM) begin
            bus_req_d   = 1'b1;
            bus_cmd_d   = CmdWb;
            bus_addr_d  = {tag_q[req_idx], req_idx};
            bus_wdata_d = data_q[req_idx];
            state_d     = StWb;
          end else begin
            bus_req_d   = 1'b1;
            bus_cmd_d   = cpu_we ? CmdRdx : CmdRd;
            bus_addr_d  = cpu_addr;
            bus_wdata_d = '0;
            state_d     = StFill;
          end
        end
      end
      StWb: begin
        if (mem_ack) begin
          mesi_d[req_idx] = MesiI;
          bus_cmd_d       = cpu_we ? CmdRdx : CmdRd;
          bus_addr_d      = cpu_addr;
          bus_wdata_d     = '0;
          state_d         = StFill;
        end
      end
      StFill: begin
        if (mem_ack) begin
          tag_d[req_idx] = req_tag;
          if (cpu_we) begin
            mesi_d[req_idx] = MesiM;
            data_d[req_idx] = cpu_wdata;
            rdata_d         = cpu_wdata;
          end else begin
            mesi_d[req_idx] = bus_shared_in ? MesiS : MesiE;
            data_d[req_idx] = mem_rdata;
            rdata_d         = mem_rdata;
          end
          bus_req_d   = 1'b0;
          bus_cmd_d   = CmdNone;
          bus_addr_d  = '0;
          state_d     = StResp;
        end
      end
      StUpgr: begin
        if (bus_gnt) begin
          mesi_d[req_idx] = MesiM;
          data_d[req_idx] = cpu_wdata;
          rdata_d         = cpu_wdata;
          bus_req_d       = 1'b0;
          bus_cmd_d       = CmdNone;
          bus_addr_d      = '0;
          state_d         = StResp;
        end else if (mesi_d[req_idx] == MesiI) begin
          // Lost the shared copy before grant: fetch it exclusively instead.
          bus_cmd_d = CmdRdx;
          state_d   = StFill;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, arrays, bus and snoop response registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      tag_q        <= '{default: '0};
      mesi_q       <= '{default: MesiI};
      data_q       <= '{default: '0};
      bus_req_q    <= 1'b0;
      bus_cmd_q    <= CmdNone;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      rdata_q      <= '0;
      snp_shared_q <= 1'b0;
      snp_flush_q  <= 1'b0;
      snp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      mesi_q       <= mesi_d;
      data_q       <= data_d;
      bus_req_q    <= bus_req_d;
      bus_cmd_q    <= bus_cmd_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      rdata_q      <= rdata_d;
      snp_shared_q <= snp_shared_d;
      snp_flush_q  <= snp_flush_d;
      snp_data_q   <= snp_data_d;
    end
  end

  assign cpu_ready    = (state_q == StResp);
  assign cpu_rdata    = rdata_q;
  assign bus_req      = bus_req_q;
  assign bus_cmd      = bus_cmd_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign snoop_shared = snp_shared_q;
  assign snoop_flush  = snp_flush_q;
  assign snoop_data   = snp_data_q;
endmodule

// File: doc/mesi_snoop_cache.md
# mesi_snoop_cache

Parametrised direct-mapped write-back cache controller implementing the full MESI protocol (I=0, S=1, M=2, E=3) for one processor on the shared snooping bus. It sits between a processor core and the common bus/memory. It serves core reads and writes, issues bus transactions on misses and upgrades, and answers snoops from peer caches. It generalises the earlier fixed 4-line/8-bit MESI logic to configurable geometry and adds victim write-back, bus arbitration and upgrade-retry.

## Interface
- ADDR_W, 5, byte address width
- DATA_W, 8, data/line width (one word per line)
- INDEX_W, 2, index bits; LINES = 2**INDEX_W; tag = ADDR_W-INDEX_W upper bits
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  core request valid, held until cpu_ready
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  request address
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data, valid with cpu_ready
- cpu_ready  out  1  one-cycle completion pulse
- bus_req  out  1  bus request, held with cmd/addr/wdata until done
- bus_gnt  in  1  arbiter grant
- bus_cmd  out  3  0 NONE, 1 BUS_RD, 2 BUS_RDX, 3 BUS_UPGR, 4 WB
- bus_addr  out  ADDR_W  transaction address
- bus_wdata  out  DATA_W  write-back data
- mem_ack  in  1  memory completion for RD/RDX/WB
- mem_rdata  in  DATA_W  fill data, valid with mem_ack
- bus_shared_in  in  1  wired-OR shared line from peers, sampled at mem_ack
- snoop_valid  in  1  peer transaction visible this cycle
- snoop_cmd  in  3  peer command (same encoding)
- snoop_addr  in  ADDR_W  peer address
- snoop_shared  out  1  registered: we held the line (S/E/M) at snoop
- snoop_flush  out  1  registered: we supply dirty data
- snoop_data  out  DATA_W  flushed data, valid with snoop_flush

## Operation
- Arrays: tag, state, data per line. Hit = state!=I and tag match.
- FSM: IDLE, WB, FILL, UPGR, RESP.
- IDLE, cpu_req: read hit (S/E/M) or write hit in M -> RESP. Write hit in E -> set M, RESP. Write hit in S -> UPGR.
- IDLE, miss: victim in M -> WB (cmd WB, victim addr/data), then FILL. Otherwise go directly to FILL. FILL uses cmd RD for reads and RDX for writes.
- WB completes on mem_ack; victim set to I.
- FILL completes on mem_ack. Installs tag/data. State on fill:
  - RD: E if bus_shared_in=0, S if 1.
  - RDX: M, with cpu_wdata merged.
- UPGR completes on bus_gnt (no mem_ack); line set to M with cpu_wdata.
- RESP: cpu_ready=1 for one cycle, cpu_rdata = line data (or the written value on writes); return to IDLE.
- Snoop, evaluated every cycle regardless of FSM state, ignored when snoop_addr equals own bus_addr while bus_gnt=1:
  - RD: M -> flush, S. E -> S. S -> S. Shared asserted if hit.
  - RDX: M -> flush, I. E/S -> I.
  - UPGR: S -> I.
  - WB/NONE: no effect.
- Upgrade retry: if in UPGR the target line is invalidated by a snoop before grant, the controller changes cmd to RDX and moves to FILL (bus_req stays high).
- Snoop and core update same line same cycle: snoop update applied first, core lookup in next cycle sees the new state.

## Timing
- Reset (async assert, sync-safe deassert): all states I, tags/data 0, FSM IDLE; cpu_ready, cpu_rdata, bus_req, bus_cmd, bus_addr, bus_wdata, snoop_shared, snoop_flush, snoop_data all 0. Reset mid-transaction drops bus_req immediately.
- Hit latency: cpu_req sampled in IDLE at edge N, cpu_ready at N+1.
- Miss latency: N+1 bus_req high; completes the cycle after mem_ack; + WB phase if dirty victim.
- bus_req, bus_cmd, bus_addr, bus_wdata stable from assertion until the completing edge; bus_req deasserts the cycle after completion. Between WB and FILL phases, bus_req stays high and the cmd changes.
- Snoop responses registered: visible one cycle after snoop_valid, held one cycle.
- cpu_req must stay high until cpu_ready; a new request is accepted no earlier than the cycle after cpu_ready.

## Test plan
- Cold read 0x05, bus_shared_in=0, mem_rdata=0xA5 -> BUS_RD, line index 1 = E, cpu_rdata=0xA5. Repeat read -> cpu_ready next cycle, no bus_req.
- Write 0x3C to same address (E) -> no bus traffic, state M. Snoop BUS_RD 0x05 -> next cycle snoop_flush=1, snoop_data=0x3C, snoop_shared=1, state S.
- Write to S line -> BUS_UPGR; grant -> M. Repeat with snoop BUS_RDX to same address before grant -> cmd switches to BUS_RDX, fill ends in M with cpu_wdata.
- Line at index 1 holds dirty 0x3C for tag of 0x05; read 0x0D -> WB at addr 0x05 data 0x3C, then BUS_RD 0x0D; bus_shared_in=1 -> S.
- Assert reset_n=0 while in FILL waiting on mem_ack -> bus_req=0 immediately, all lines I, next read of 0x05 misses.
